// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: round-robin sharing of one master_dma engine among NUM_CH channels.
// Optional watchdog (macro DMA_TIMEOUT_EN) aborts a stuck transfer and pulses ch_err.
//
// state    | meaning
// IDLE     | arbitrate pending requests, latch the winner's descriptor
// LAUNCH   | pulse dma_trigger to master_dma
// WAIT     | wait for a rising edge on dma_done (watchdog runs if enabled)
// COMPLETE | pulse ch_done for the active channel
module dma_channel_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int ADDR_W         = 32,
    parameter int LEN_W          = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_src,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_dst,
    input  logic [NUM_CH*LEN_W-1:0]    ch_len,
    output logic [NUM_CH-1:0]          ch_grant,
    output logic [NUM_CH-1:0]          ch_done,
    output logic                       dma_trigger,
    output logic [LEN_W-1:0]           dma_length,
    output logic [ADDR_W-1:0]          dma_source_address,
    output logic [ADDR_W-1:0]          dma_destination_address,
    input  logic                       dma_done,
    output logic                       busy,
    output logic [CH_W-1:0]            active_ch
`ifdef DMA_TIMEOUT_EN
    ,
    output logic [NUM_CH-1:0]          ch_err
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT     = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CH_W-1:0]   last_grant;
    logic              done_q;
    logic              done_rise;
    logic              timeout_hit;

    logic              req_any;
    logic [CH_W-1:0]   win;
    logic [CH_W:0]     cand;
    logic [ADDR_W-1:0] win_src;
    logic [ADDR_W-1:0] win_dst;
    logic [LEN_W-1:0]  win_len;

    logic              grant_load;
    logic              trigger_d;
    logic              done_d;
    logic              err_d;

    assign done_rise = dma_done & ~done_q;
    assign busy      = (state_q != IDLE);

    // Search upward from last_grant+1, wrapping, so the last winner has lowest priority.
    always_comb begin
        win     = '0;
        req_any = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = {1'b0, last_grant} + (CH_W+1)'(k);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!req_any && ch_req[cand[CH_W-1:0]]) begin
                win     = cand[CH_W-1:0];
                req_any = 1'b1;
            end
        end
    end

    always_comb begin
        win_src = '0;
        win_dst = '0;
        win_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win == CH_W'(i)) begin
                win_src = ch_src[i*ADDR_W +: ADDR_W];
                win_dst = ch_dst[i*ADDR_W +: ADDR_W];
                win_len = ch_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= dma_done;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = (win_len == '0) ? COMPLETE : LAUNCH;
                end
            end
            LAUNCH:   state_d = WAIT;
            WAIT: begin
                if (done_rise) begin
                    state_d = COMPLETE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_load = 1'b0;
        trigger_d  = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE:     grant_load = req_any;
            LAUNCH:   trigger_d  = 1'b1;
            WAIT:     err_d      = !done_rise && timeout_hit;
            COMPLETE: done_d     = 1'b1;
            default: ;
        endcase
    end

    // Descriptor outputs hold from one grant to the next; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            ch_grant                <= '0;
            ch_done                 <= '0;
            dma_trigger             <= 1'b0;
            dma_length              <= '0;
            dma_source_address      <= '0;
            dma_destination_address <= '0;
            active_ch               <= '0;
            last_grant              <= CH_W'(NUM_CH - 1);
        end else begin
            ch_grant    <= '0;
            ch_done     <= '0;
            dma_trigger <= trigger_d;
            if (grant_load) begin
                ch_grant                <= NUM_CH'(1) << win;
                active_ch               <= win;
                last_grant              <= win;
                dma_length              <= win_len;
                dma_source_address      <= win_src;
                dma_destination_address <= win_dst;
            end
            if (done_d) begin
                ch_done <= NUM_CH'(1) << active_ch;
            end
        end
    end

`ifdef DMA_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign timeout_hit = (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            ch_err <= '0;
        end else begin
            ch_err <= '0;
            if (state_q == LAUNCH) begin
                wd_cnt <= '0;
            end else if (state_q == WAIT && !timeout_hit) begin
                wd_cnt <= wd_cnt + 16'd1;
            end
            if (err_d) begin
                ch_err <= NUM_CH'(1) << active_ch;
            end
        end
    end
`else
    logic [16:0] unused_cfg;

    assign timeout_hit = 1'b0;
    assign unused_cfg  = {err_d, 16'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Bench for dma_channel_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin model.
module tb_dma_channel_arbiter;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 5;
    localparam int TO_CYC = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_src;
    logic [NUM_CH*ADDR_W-1:0] ch_dst;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [NUM_CH-1:0]        ch_grant;
    logic [NUM_CH-1:0]        ch_done;
    logic                     dma_trigger;
    logic [LEN_W-1:0]         dma_length;
    logic [ADDR_W-1:0]        dma_source_address;
    logic [ADDR_W-1:0]        dma_destination_address;
    logic                     dma_done;
    logic                     busy;
    logic [CH_W-1:0]          active_ch;
`ifdef DMA_TIMEOUT_EN
    logic [NUM_CH-1:0]        ch_err;
`endif

    dma_channel_arbiter #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch_req(ch_req),
        .ch_src(ch_src),
        .ch_dst(ch_dst),
        .ch_len(ch_len),
        .ch_grant(ch_grant),
        .ch_done(ch_done),
        .dma_trigger(dma_trigger),
        .dma_length(dma_length),
        .dma_source_address(dma_source_address),
        .dma_destination_address(dma_destination_address),
        .dma_done(dma_done),
        .busy(busy),
        .active_ch(active_ch)
`ifdef DMA_TIMEOUT_EN
        ,
        .ch_err(ch_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ptr;

    logic [ADDR_W-1:0] src [NUM_CH];
    logic [ADDR_W-1:0] dst [NUM_CH];
    logic [LEN_W-1:0]  len [NUM_CH];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_desc();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_src[i*ADDR_W +: ADDR_W] = src[i];
            ch_dst[i*ADDR_W +: ADDR_W] = dst[i];
            ch_len[i*LEN_W +: LEN_W]   = len[i];
        end
    endtask

    task automatic randomize_desc();
        for (int i = 0; i < NUM_CH; i++) begin
            src[i] = $urandom;
            dst[i] = $urandom;
            len[i] = ($urandom_range(0, 5) == 0) ? '0 : LEN_W'($urandom_range(1, 31));
        end
        drive_desc();
    endtask

    // Reference round-robin choice: first requester after the last winner, wrapping.
    function automatic int rr_pick(input logic [NUM_CH-1:0] req, input int last);
        int c;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (last + k) % NUM_CH;
            if (req[c[CH_W-1:0]]) return c;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_grant"}, 64'(ch_grant), 64'd0);
        check_eq({tag, "_done"}, 64'(ch_done), 64'd0);
        check_eq({tag, "_trigger"}, 64'(dma_trigger), 64'd0);
        check_eq({tag, "_len"}, 64'(dma_length), 64'd0);
        check_eq({tag, "_src"}, 64'(dma_source_address), 64'd0);
        check_eq({tag, "_dst"}, 64'(dma_destination_address), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_active"}, 64'(active_ch), 64'd0);
    endtask

    // One full transfer starting from IDLE; exp_w >= 0 also pins the granted channel.
    task automatic do_xfer(input logic [NUM_CH-1:0] req, input int exp_w, input int wait_cyc);
        int                w;
        logic [ADDR_W-1:0] s;
        logic [ADDR_W-1:0] d;
        logic [LEN_W-1:0]  l;
        ch_req = req;
        w = rr_pick(req, ptr);
        s = src[w];
        d = dst[w];
        l = len[w];
        tick();
        ptr = w;
        if (exp_w >= 0) check_eq("grant_dir", 64'(ch_grant), 64'(1) << exp_w);
        check_eq("grant", 64'(ch_grant), 64'(1) << w);
        check_eq("active_ch", 64'(active_ch), 64'(w));
        check_eq("busy_grant", 64'(busy), 64'd1);
        check_eq("trig_at_grant", 64'(dma_trigger), 64'd0);
        check_eq("len_at_grant", 64'(dma_length), 64'(l));
        check_eq("src_at_grant", 64'(dma_source_address), 64'(s));
        check_eq("dst_at_grant", 64'(dma_destination_address), 64'(d));
        // Disturb the granted descriptor; the running transfer must not see it.
        src[w] = ~src[w];
        dst[w] = $urandom;
        len[w] = len[w] + 1'b1;
        drive_desc();
        ch_req[w] = 1'($urandom_range(0, 1));
        if (l == '0) begin
            tick();
            check_eq("zl_trigger", 64'(dma_trigger), 64'd0);
            check_eq("zl_grant_off", 64'(ch_grant), 64'd0);
            check_eq("zl_done", 64'(ch_done), 64'(1) << w);
            check_eq("zl_busy", 64'(busy), 64'd0);
        end else begin
            tick();
            check_eq("trigger", 64'(dma_trigger), 64'd1);
            check_eq("grant_off", 64'(ch_grant), 64'd0);
            check_eq("len_at_trig", 64'(dma_length), 64'(l));
            check_eq("src_at_trig", 64'(dma_source_address), 64'(s));
            check_eq("dst_at_trig", 64'(dma_destination_address), 64'(d));
            // dma_done keeps its previous level here, so a stale high must be ignored.
            for (int i = 0; i < wait_cyc; i++) begin
                tick();
                check_eq("wait_trigger", 64'(dma_trigger), 64'd0);
                check_eq("wait_no_done", 64'(ch_done), 64'd0);
                check_eq("wait_busy", 64'(busy), 64'd1);
            end
            dma_done = 1'b0;
            tick();
            check_eq("pre_rise_no_done", 64'(ch_done), 64'd0);
            dma_done = 1'b1;
            tick();
            check_eq("rise_edge_no_done", 64'(ch_done), 64'd0);
            check_eq("rise_edge_busy", 64'(busy), 64'd1);
            tick();
            check_eq("done", 64'(ch_done), 64'(1) << w);
            check_eq("done_busy", 64'(busy), 64'd0);
            check_eq("src_held", 64'(dma_source_address), 64'(s));
            if ($urandom_range(0, 1) == 1) dma_done = 1'b0;
        end
    endtask

    initial begin
        reset    = 1'b1;
        ch_req   = '0;
        dma_done = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            src[i] = '0;
            dst[i] = '0;
            len[i] = '0;
        end
        drive_desc();
        ptr = NUM_CH - 1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check_eq("idle_grant", 64'(ch_grant), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Single channel-0 transfer with known descriptor.
        src[0] = 32'h0000_1000;
        dst[0] = 32'h0000_2000;
        len[0] = 5'd16;
        drive_desc();
        do_xfer(4'b0001, 0, 2);

        // All channels requesting from the reset pointer: 0,1,2,3,0.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ptr = NUM_CH - 1;
        randomize_desc();
        do_xfer(4'b1111, 0, 1);
        do_xfer(4'b1111, 1, 0);
        do_xfer(4'b1111, 2, 3);
        do_xfer(4'b1111, 3, 1);
        do_xfer(4'b1111, 0, 2);

        // Only channels 1 and 3 requesting.
        do_xfer(4'b1010, 1, 1);
        do_xfer(4'b1010, 3, 0);
        do_xfer(4'b1010, 1, 2);
        do_xfer(4'b1010, 3, 1);

        // Zero-length descriptor on channel 2.
        len[2] = '0;
        drive_desc();
        do_xfer(4'b0100, 2, 0);

        // Reset while channel 1 sits in WAIT.
        len[1]   = 5'd7;
        drive_desc();
        dma_done = 1'b0;
        ch_req   = 4'b0010;
        tick();
        check_eq("rst_grant_ch1", 64'(ch_grant), 64'b0010);
        tick();
        tick();
        tick();
        check_eq("rst_in_wait", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        check_all_zero("mid_reset");
        reset = 1'b0;
        ptr = NUM_CH - 1;
        do_xfer(4'b0011, 0, 1);

        // Randomized traffic, with occasional idle gaps.
        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 3) == 0) randomize_desc();
            if ($urandom_range(0, 7) == 0) begin
                ch_req = '0;
                tick();
                check_eq("gap_grant", 64'(ch_grant), 64'd0);
                check_eq("gap_busy", 64'(busy), 64'd0);
            end
            do_xfer(4'($urandom_range(1, 15)), -1, $urandom_range(0, 4));
        end

`ifdef DMA_TIMEOUT_EN
        // Watchdog: done never rises, ch_err fires TO_CYC cycles after WAIT entry.
        dma_done = 1'b0;
        len[3]   = 5'd9;
        drive_desc();
        ch_req = 4'b1000;
        tick();
        check_eq("to_grant", 64'(ch_grant), 64'b1000);
        ch_req = '0;
        tick();
        check_eq("to_trigger", 64'(dma_trigger), 64'd1);
        for (int i = 1; i < TO_CYC; i++) begin
            tick();
            check_eq("to_no_err", 64'(ch_err), 64'd0);
        end
        tick();
        check_eq("to_err", 64'(ch_err), 64'b1000);
        check_eq("to_no_done", 64'(ch_done), 64'd0);
        check_eq("to_idle", 64'(busy), 64'd0);
        tick();
        check_eq("to_err_pulse", 64'(ch_err), 64'd0);
        check_eq("to_no_done2", 64'(ch_done), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
